imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_if.sv | 33 +++
 rtl/imem_word_packer.sv | 37 +++
 rtl/imem_loader.sv | 127 ++++++++++++
 tb/tb_imem_loader.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEFAULT_ADDR_W = 8;

  // Loader FSM states: wait for start, read COUNT, stream words, check CHK.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DATA  = 2'd2,
    CHK   = 2'd3
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Loader-side bundle: start pulse, byte stream, imem write port and status.
// Latency: n/a (wires only).
// Backpressure: rx_ready qualifies rx_valid; the imem write port has none.
interface imem_loader_if #(
  parameter int ADDR_W = imem_loader_pkg::DEFAULT_ADDR_W,
  parameter int DATA_W = 32
);

  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;

  // The loader itself.
  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, error
  );

  // Whoever feeds the byte stream and watches the status.
  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, error
  );

endinterface

// File: rtl/imem_word_packer.sv
// Byte-to-word shift register; first byte of a word lands in the top byte.
// Latency: word_vld/word_dat are combinational with the 4th accepted byte.
// Backpressure: none; shifts only when byte_vld is high.
module imem_word_packer
  import imem_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_vld,
  input  logic [7:0]        byte_dat,
  output logic              word_vld,
  output logic [DATA_W-1:0] word_dat
);

  logic [DATA_W-9:0] shift_q;
  logic [1:0]        cnt_q;

  // Collect the first three bytes of a word; the byte counter wraps every word.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_vld) begin
      shift_q <= {shift_q[DATA_W-17:0], byte_dat};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

  // The 4th byte completes the word straight from the input, so the top level
  // can register the write one cycle after acceptance.
  assign word_vld = byte_vld && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word_dat = {shift_q, byte_dat};

endmodule

// File: rtl/imem_loader.sv
// Framed-stream loader into instruction memory; holds the CPU in reset until a good image.
// Latency: imem write and done/error/cpu_reset updates appear the cycle after the byte.
// Backpressure: rx_ready is high in every non-idle state; one byte per clock sustained.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave io
);

  // COUNT byte of zero means a full memory image.
  localparam logic [ADDR_W:0] WORDS_FULL = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic              rdy;
  logic              accept;
  logic              start_acc;
  logic              byte_vld;
  logic              word_vld;
  logic [DATA_W-1:0] word_dat;
  logic              last_word;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   words_left_q;
  logic [7:0]        chk_q;

  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              cpu_reset_q;
  logic              done_q;
  logic              error_q;

  assign rdy       = (state_q != IDLE);
  assign accept    = io.rx_valid && rdy;
  assign start_acc = (state_q == IDLE) && io.start;
  assign byte_vld  = accept && (state_q == DATA);
  assign last_word = (words_left_q == (ADDR_W + 1)'(1));

  imem_word_packer #(.DATA_W(DATA_W)) u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_acc),
    .byte_vld (byte_vld),
    .byte_dat (io.rx_data),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: start opens a frame, the last word moves on to the checksum byte.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (io.start)                state_d = COUNT;
      COUNT:   if (accept)                  state_d = DATA;
      DATA:    if (word_vld && last_word)   state_d = CHK;
      CHK:     if (accept)                  state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  // Outputs: handshake/status from state, the rest straight from registers.
  always_comb begin
    io.rx_ready   = rdy;
    io.busy       = rdy;
    io.imem_we    = we_q;
    io.imem_addr  = waddr_q;
    io.imem_wdata = wdata_q;
    io.cpu_reset  = cpu_reset_q;
    io.done       = done_q;
    io.error      = error_q;
  end

  // Datapath: address/word counters, running XOR and registered write/status.
  // The write address is a separate register so it holds after the counter moves on.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      words_left_q <= '0;
      chk_q        <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (start_acc) begin
        error_q     <= 1'b0;
        cpu_reset_q <= 1'b1;
      end
      if (accept && (state_q == COUNT)) begin
        words_left_q <= (io.rx_data == 8'd0) ? WORDS_FULL : (ADDR_W + 1)'(io.rx_data);
        chk_q        <= io.rx_data;
        addr_q       <= '0;
      end
      if (byte_vld) begin
        chk_q <= chk_q ^ io.rx_data;
      end
      if (word_vld) begin
        we_q         <= 1'b1;
        waddr_q      <= addr_q;
        wdata_q      <= word_dat;
        addr_q       <= addr_q + 1'b1;
        words_left_q <= words_left_q - 1'b1;
      end
      if (accept && (state_q == CHK)) begin
        done_q <= 1'b1;
        if (io.rx_data == chk_q) cpu_reset_q <= 1'b0;
        else                     error_q     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table rows, hand sequences, random frames.
// Latency: checks done/error/cpu_reset one cycle after the CHK byte.
// Backpressure: drives rx_valid with gaps; expects rx_ready high for a whole frame.
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(8), .DATA_W(32)) io ();
  imem_loader #(.ADDR_W(8), .DATA_W(32)) dut (.clk(clk), .reset(reset), .io(io));

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [7:0] count_b;
    int         gap_mode;
    logic [7:0] chk_mask;
    int         exp_writes;
    logic       exp_err;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_seen = 0;
  int          rdy_low  = 0;
  logic        in_frame = 1'b0;
  wr_t         obs_q[$];
  logic [31:0] frame_words[$];

  // Capture every memory write and done pulse; watch rx_ready inside frames.
  always @(negedge clk) begin
    if (io.imem_we) obs_q.push_back('{io.imem_addr, io.imem_wdata});
    if (io.done) done_seen++;
    if (in_frame && !io.rx_ready) rdy_low++;
  end

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_b({tag, "_rx_ready"}, io.rx_ready, 1'b0);
    check_b({tag, "_we"}, io.imem_we, 1'b0);
    check_w({tag, "_addr"}, 32'(io.imem_addr), 32'h0);
    check_w({tag, "_wdata"}, io.imem_wdata, 32'h0);
    check_b({tag, "_cpu_reset"}, io.cpu_reset, 1'b1);
    check_b({tag, "_busy"}, io.busy, 1'b0);
    check_b({tag, "_done"}, io.done, 1'b0);
    check_b({tag, "_error"}, io.error, 1'b0);
  endtask

  // Pulse start from IDLE; one cycle later the loader must be busy and ready.
  task automatic do_start();
    io.start = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    @(negedge clk);
    check_b("start_busy", io.busy, 1'b1);
    check_b("start_rx_ready", io.rx_ready, 1'b1);
    check_b("start_error_clear", io.error, 1'b0);
    check_b("start_cpu_reset", io.cpu_reset, 1'b1);
    @(posedge clk); #1;
  endtask

  // Offer one byte after `gap` idle cycles; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    io.rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    io.rx_data  = b;
    io.rx_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!io.rx_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!io.rx_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_ready_timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    io.rx_valid = 1'b0;
  endtask

  function automatic int pick_gap(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(0, 2));
  endfunction

  // Reference model: expected writes are word i at address i mod 256, the checksum
  // is the XOR of COUNT and every data byte, and error means the sent CHK differs.
  task automatic run_frame(input logic [7:0] count_b, input logic [7:0] chk_mask,
                           input int gap_mode, input logic exp_err, input int inject_at);
    logic [7:0] chk;
    logic [7:0] b;
    int         d0;
    int         n;
    n = frame_words.size();
    do_start();
    obs_q.delete();
    d0       = done_seen;
    rdy_low  = 0;
    in_frame = 1'b1;
    chk = count_b;
    send_byte(count_b, 0);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (i * 4 + j == inject_at) begin
          io.start = 1'b1;
          @(posedge clk); #1;
          io.start = 1'b0;
          @(negedge clk);
          check_b("start_ignored_busy", io.busy, 1'b1);
          @(posedge clk); #1;
        end
        b = frame_words[i][31 - 8 * j -: 8];
        chk = chk ^ b;
        send_byte(b, pick_gap(gap_mode));
      end
    end
    send_byte(chk ^ chk_mask, pick_gap(gap_mode));
    in_frame = 1'b0;
    @(negedge clk);
    check_b("done_pulse", io.done, 1'b1);
    check_b("done_error", io.error, exp_err);
    check_b("done_cpu_reset", io.cpu_reset, exp_err);
    check_b("done_busy", io.busy, 1'b0);
    @(negedge clk);
    check_b("done_single_cycle", io.done, 1'b0);
    check_b("error_sticky", io.error, exp_err);
    check_w("done_count", done_seen - d0, 1);
    check_w("rx_ready_held", rdy_low, 0);
    check_w("write_count", obs_q.size(), n);
    for (int i = 0; i < n && i < obs_q.size(); i++) begin
      check_w("write_addr", 32'(obs_q[i].a), i & 32'hFF);
      check_w("write_data", obs_q[i].d, frame_words[i]);
    end
    @(posedge clk); #1;
  endtask

  task automatic fill_random(input int n);
    frame_words.delete();
    for (int i = 0; i < n; i++) frame_words.push_back($urandom);
  endtask

  vec_t vt[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] mask;
    vt[0] = '{8'd1, 0, 8'h00, 1, 1'b0};
    vt[1] = '{8'd3, 1, 8'h00, 3, 1'b0};
    vt[2] = '{8'd2, 0, 8'h01, 2, 1'b1};
    vt[3] = '{8'd5, 2, 8'h00, 5, 1'b0};
    vt[4] = '{8'd4, 2, 8'h80, 4, 1'b1};

    reset = 1'b1;
    io.start = 1'b0;
    io.rx_valid = 1'b0;
    io.rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("por");
    @(posedge clk); #1;
    reset = 1'b0;

    // One-word literal frame: 01 3C 08 00 10, checksum 25.
    do_start();
    obs_q.delete();
    send_byte(8'h01, 0);
    send_byte(8'h3C, 0);
    send_byte(8'h08, 0);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    send_byte(8'h25, 0);
    @(negedge clk);
    check_b("lit_done", io.done, 1'b1);
    check_b("lit_error", io.error, 1'b0);
    check_b("lit_cpu_reset", io.cpu_reset, 1'b0);
    check_w("lit_writes", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      check_w("lit_addr", 32'(obs_q[0].a), 32'h0);
      check_w("lit_data", obs_q[0].d, 32'h3C080010);
    end
    @(posedge clk); #1;

    // Table rows: random payloads, fixed framing/expectations.
    for (int r = 0; r < 5; r++) begin
      fill_random(vt[r].exp_writes);
      run_frame(vt[r].count_b, vt[r].chk_mask, vt[r].gap_mode, vt[r].exp_err, -1);
    end

    // Full-memory image via COUNT 0: word i = i, back-to-back.
    frame_words.delete();
    for (int i = 0; i < 256; i++) frame_words.push_back(i);
    run_frame(8'h00, 8'h00, 0, 1'b0, -1);

    // start pulsed mid-DATA must not disturb the load.
    fill_random(2);
    run_frame(8'd2, 8'h00, 0, 1'b0, 3);

    // Reset after 6 data bytes of a 2-word load.
    do_start();
    obs_q.delete();
    send_byte(8'd2, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    @(negedge clk);
    check_w("midrst_writes", obs_q.size(), 1);
    check_b("midrst_busy_before", io.busy, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    @(posedge clk); #1;

    // start together with reset: reset wins.
    reset = 1'b1;
    io.start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    io.start = 1'b0;
    @(negedge clk);
    check_b("rst_start_busy", io.busy, 1'b0);
    check_b("rst_start_rx_ready", io.rx_ready, 1'b0);
    @(posedge clk); #1;

    // Random frames with random valid gaps and occasional checksum bit flips.
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(1, 6));
      fill_random(n);
      mask = ($urandom_range(0, 3) == 0) ? 8'(8'h01 << $urandom_range(0, 7)) : 8'h00;
      run_frame(8'(n), mask, 2, (mask != 8'h00), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
